// File: rtl/axil_wr_vote_if.sv
// AXI4-lite write-channel bundle; LANES > 1 packs several lanes side by side.
interface axil_wr_vote_if #(
    parameter int unsigned LANES      = 1,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic [LANES*ADDR_WIDTH-1:0] awaddr;
    logic [LANES*3-1:0]          awprot;
    logic [LANES-1:0]            awvalid;
    logic [LANES-1:0]            awready;
    logic [LANES*DATA_WIDTH-1:0] wdata;
    logic [LANES*STRB_WIDTH-1:0] wstrb;
    logic [LANES-1:0]            wvalid;
    logic [LANES-1:0]            wready;
    logic [LANES*2-1:0]          bresp;
    logic [LANES-1:0]            bvalid;
    logic [LANES-1:0]            bready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axil_wr_vote.sv
// M_COUNT-to-1 AXI4-lite write voter: accepts one write from every redundant
// lane, forwards it downstream only if all lanes agree with lane 0, and
// broadcasts the resulting response back to every lane.
module axil_wr_vote #(
    parameter int unsigned M_COUNT    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic           clk,
    input  logic           rst,
    axil_wr_vote_if.slave  s_axil,
    axil_wr_vote_if.master m_axil,
    output logic           vote_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        ISSUE = 3'd2,
        RESP  = 3'd3,
        BCAST = 3'd4
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t state, state_next;

    logic [M_COUNT-1:0] awready_q, awready_d;
    logic [M_COUNT-1:0] wready_q, wready_d;
    logic [M_COUNT-1:0] bvalid_q, bvalid_d;
    logic               m_awvalid_q, m_awvalid_d;
    logic               m_wvalid_q, m_wvalid_d;
    logic               m_bready_q, m_bready_d;
    logic               vote_err_q, vote_err_d;

    logic               aw_load, w_load, b_load;
    logic [1:0]         bresp_d;
    logic               aw_mis_c, w_mis_c;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            prot_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic [1:0]            bresp_q;
    logic                  aw_mis_q;

    // Lane-vs-lane-0 comparison of the AW and W payloads currently presented.
    always_comb begin
        aw_mis_c = 1'b0;
        w_mis_c  = 1'b0;
        for (int unsigned n = 1; n < M_COUNT; n++) begin
            if (s_axil.awaddr[n*ADDR_WIDTH +: ADDR_WIDTH] != s_axil.awaddr[ADDR_WIDTH-1:0] ||
                s_axil.awprot[n*3 +: 3] != s_axil.awprot[2:0]) begin
                aw_mis_c = 1'b1;
            end
            if (s_axil.wdata[n*DATA_WIDTH +: DATA_WIDTH] != s_axil.wdata[DATA_WIDTH-1:0] ||
                s_axil.wstrb[n*STRB_WIDTH +: STRB_WIDTH] != s_axil.wstrb[STRB_WIDTH-1:0]) begin
                w_mis_c = 1'b1;
            end
        end
    end

    // Next-state and next-output logic for the collect/issue/respond sequence.
    always_comb begin
        state_next  = state;
        awready_d   = '0;
        wready_d    = '0;
        bvalid_d    = bvalid_q;
        m_awvalid_d = m_awvalid_q;
        m_wvalid_d  = m_wvalid_q;
        m_bready_d  = m_bready_q;
        vote_err_d  = 1'b0;
        aw_load     = 1'b0;
        w_load      = 1'b0;
        b_load      = 1'b0;
        bresp_d     = 2'b00;

        unique case (state)
            IDLE: begin
                // awready is a one-cycle all-lane pulse, so its cycle is the joint handshake
                if (|awready_q) begin
                    aw_load    = 1'b1;
                    state_next = DATA;
                end else if (&s_axil.awvalid) begin
                    awready_d = '1;
                end
            end
            DATA: begin
                if (|wready_q) begin
                    w_load = 1'b1;
                    if (aw_mis_q || w_mis_c) begin
                        bresp_d    = RESP_SLVERR;
                        b_load     = 1'b1;
                        vote_err_d = 1'b1;
                        bvalid_d   = '1;
                        state_next = BCAST;
                    end else begin
                        m_awvalid_d = 1'b1;
                        m_wvalid_d  = 1'b1;
                        state_next  = ISSUE;
                    end
                end else if (&s_axil.wvalid) begin
                    wready_d = '1;
                end
            end
            ISSUE: begin
                if (m_awvalid_q && m_axil.awready) begin
                    m_awvalid_d = 1'b0;
                end
                if (m_wvalid_q && m_axil.wready) begin
                    m_wvalid_d = 1'b0;
                end
                if (!m_awvalid_d && !m_wvalid_d) begin
                    m_bready_d = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (m_axil.bvalid && m_bready_q) begin
                    bresp_d    = m_axil.bresp;
                    b_load     = 1'b1;
                    m_bready_d = 1'b0;
                    bvalid_d   = '1;
                    state_next = BCAST;
                end
            end
            BCAST: begin
                bvalid_d = bvalid_q & ~s_axil.bready;
                if (bvalid_d == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control state and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            awready_q   <= '0;
            wready_q    <= '0;
            bvalid_q    <= '0;
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
            vote_err_q  <= 1'b0;
        end else begin
            state       <= state_next;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            m_awvalid_q <= m_awvalid_d;
            m_wvalid_q  <= m_wvalid_d;
            m_bready_q  <= m_bready_d;
            vote_err_q  <= vote_err_d;
        end
    end

    // Payload capture from lane 0; only read after being loaded, so no reset.
    always_ff @(posedge clk) begin
        if (aw_load) begin
            addr_q   <= s_axil.awaddr[ADDR_WIDTH-1:0];
            prot_q   <= s_axil.awprot[2:0];
            aw_mis_q <= aw_mis_c;
        end
        if (w_load) begin
            data_q <= s_axil.wdata[DATA_WIDTH-1:0];
            strb_q <= s_axil.wstrb[STRB_WIDTH-1:0];
        end
        if (b_load) begin
            bresp_q <= bresp_d;
        end
    end

    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = {M_COUNT{bresp_q}};

    assign m_axil.awaddr  = addr_q;
    assign m_axil.awprot  = prot_q;
    assign m_axil.awvalid = m_awvalid_q;
    assign m_axil.wdata   = data_q;
    assign m_axil.wstrb   = strb_q;
    assign m_axil.wvalid  = m_wvalid_q;
    assign m_axil.bready  = m_bready_q;

    assign vote_err = vote_err_q;

endmodule
